// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts one fetch at a time, returns the addressed word after
// WAIT_STATES cycles, and flags misaligned / out-of-range fetches. Side port loads the image.
module imem_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [31:0]                    rsp_addr,
  output logic [1:0]                     rsp_fault,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] req_word;
  logic [1:0]  req_fault;
  logic [AW-1:0] rd_idx;
  logic [31:0] rd_data;

  assign req_ready = (state_q == S_IDLE) && reset;

  // Full 30-bit word index is compared, so high addresses never wrap into the array.
  assign req_word  = {2'b00, req_addr[31:2]};
  assign req_fault = (req_addr[1:0] != 2'b00) ? 2'b01 :
                     (req_word >= DEPTH_L)    ? 2'b10 : 2'b00;

  // In IDLE the read only matters for the zero-wait path, which uses the live request.
  assign rd_idx  = (state_q == S_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
  assign rd_data = mem_q[rd_idx];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_fault != 2'b00) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_instr_d = FAULT_INSTR;
            rsp_addr_d  = req_addr;
            rsp_fault_d = req_fault;
          end else if (WAIT_STATES == 0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_instr_d = rd_data;
            rsp_addr_d  = req_addr;
            rsp_fault_d = 2'b00;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_instr_d = rd_data;
          rsp_addr_d  = addr_q;
          rsp_fault_d = 2'b00;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'd0;
      rsp_addr_q  <= 32'd0;
      rsp_fault_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Program image survives reset; a same-edge load is seen only by later reads.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[load_addr] <= load_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: three instances (0, 1 and 3 wait states) share the load port
// and reset; each fetch is checked against a word-array model of the program image.
module tb_imem_fetch_responder;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        req_valid, rsp_ready;
  logic [N-1:0][31:0]  req_addr;
  wire  [N-1:0]        req_ready, rsp_valid;
  wire  [N-1:0][31:0]  rsp_instr, rsp_addr;
  wire  [N-1:0][1:0]   rsp_fault;
  logic                load_we;
  logic [7:0]          load_addr;
  logic [31:0]         load_data;

  logic [31:0] mdl [256];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH_WORDS(256), .WAIT_STATES(g == 2 ? 3 : g), .FAULT_INSTR(32'h0000_0013)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_instr(rsp_instr[g]), .rsp_addr(rsp_addr[g]), .rsp_fault(rsp_fault[g]),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );
  end

  function automatic int ws_of(int d);
    return (d == 2) ? 3 : d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int a, logic [31:0] v);
    load_we = 1'b1; load_addr = 8'(a); load_data = v;
    tick();
    load_we = 1'b0;
    mdl[a] = v;
  endtask

  // One complete transaction on instance d. hold = cycles rsp_ready stays low in RESP;
  // poke drives a stray request during that hold; coll writes the fetched word on the
  // edge that enters RESP.
  task automatic fetch(int d, logic [31:0] a, int hold, bit poke, bit coll, logic [31:0] cval);
    logic [1:0]  ef;
    logic [31:0] ei;
    int lat, n;
    ef  = (a[1:0] != 2'b00) ? 2'b01 : ((a >> 2) >= 32'd256) ? 2'b10 : 2'b00;
    lat = (ef != 2'b00) ? 1 : ws_of(d) + 1;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    n = 0;
    while (!req_ready[d] && n < 20) begin tick(); n++; end
    if (!req_ready[d]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    ei = (ef != 2'b00) ? 32'h0000_0013 : mdl[a[9:2]];
    for (int k = 1; k <= lat; k++) begin
      if (coll && k == lat) begin load_we = 1'b1; load_addr = a[9:2]; load_data = cval; end
      tick();
      load_we = 1'b0;
      if (k == 1) req_valid[d] = 1'b0;
      chk("busy_ready", 32'(req_ready[d]), 32'd0);
      if (k < lat) chk("early_valid", 32'(rsp_valid[d]), 32'd0);
    end
    if (coll) mdl[a[9:2]] = cval;
    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk("rsp_instr", rsp_instr[d], ei);
    chk("rsp_addr", rsp_addr[d], a);
    chk("rsp_fault", 32'(rsp_fault[d]), 32'(ef));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin req_valid[d] = 1'b1; req_addr[d] = a ^ 32'h4; end
      tick();
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_instr", rsp_instr[d], ei);
      chk("hold_addr", rsp_addr[d], a);
      chk("hold_fault", 32'(rsp_fault[d]), 32'(ef));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    chk("post_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_ready", 32'(req_ready[d]), 32'd1);
    chk("post_addr", rsp_addr[d], a);
    chk("post_instr", rsp_instr[d], ei);
  endtask

  task automatic chk_all_zero(string tag);
    for (int d = 0; d < N; d++) begin
      chk({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready[d]), 32'd0);
      chk({tag, "_instr"}, rsp_instr[d], 32'd0);
      chk({tag, "_addr"}, rsp_addr[d], 32'd0);
      chk({tag, "_fault"}, 32'(rsp_fault[d]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[$];
    int i_req, i_rsp, r;
    logic [31:0] a;
    req_valid = '0; rsp_ready = '0; req_addr = '0;
    load_we = 1'b0; load_addr = 8'd0; load_data = 32'd0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    #1;
    for (int d = 0; d < N; d++) chk("ready_after_reset", 32'(req_ready[d]), 32'd1);

    for (int i = 0; i < 256; i++) load(i, $urandom);

    // Basic fetch and stall with stray request
    load(0, 32'h0050_0093);
    fetch(1, 32'h0, 0, 1'b0, 1'b0, 32'd0);
    fetch(1, 32'h0, 5, 1'b1, 1'b0, 32'd0);

    // Faults, including misaligned-over-range priority and no wrap at the top
    fetch(1, 32'h0000_0006, 0, 1'b0, 1'b0, 32'd0);
    fetch(1, 32'h0000_0400, 0, 1'b0, 1'b0, 32'd0);
    fetch(0, 32'hFFFF_FFFC, 1, 1'b0, 1'b0, 32'd0);
    fetch(2, 32'hFFFF_FFFE, 0, 1'b0, 1'b0, 32'd0);
    fetch(2, 32'h0000_03FC, 0, 1'b0, 1'b0, 32'd0);

    // Back-to-back on the zero-wait instance
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
    i_req = 0; i_rsp = 0;
    for (int c = 0; c < 20 && i_rsp < 3; c++) begin
      bit acc, hs;
      acc = req_valid[0] && req_ready[0];
      hs  = rsp_valid[0] && rsp_ready[0];
      if (hs) begin
        chk("b2b_addr", rsp_addr[0], 32'(4 * i_rsp));
        chk("b2b_instr", rsp_instr[0], mdl[i_rsp]);
        i_rsp++;
      end
      tick();
      if (acc) begin
        acc_cyc.push_back(c);
        i_req++;
        if (i_req < 3) req_addr[0] = 32'(4 * i_req); else req_valid[0] = 1'b0;
      end
    end
    rsp_ready[0] = 1'b0; req_valid[0] = 1'b0;
    chk("b2b_rsp_count", 32'(i_rsp), 32'd3);
    chk("b2b_acc_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end
    tick();

    // Reset while waiting drops the pending response
    req_valid[2] = 1'b1; req_addr[2] = 32'h10;
    tick();
    req_valid[2] = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    chk_all_zero("midreset_held");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dropped_rsp", 32'(rsp_valid[2]), 32'd0);
    end
    fetch(2, 32'h10, 0, 1'b0, 1'b0, 32'd0);

    // Load colliding with the read edge returns the old word, then the new one
    fetch(1, 32'hC, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    fetch(1, 32'hC, 0, 1'b0, 1'b0, 32'd0);
    fetch(0, 32'h20, 0, 1'b0, 1'b1, 32'h1234_5678);
    fetch(0, 32'h20, 0, 1'b0, 1'b0, 32'd0);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      int d;
      bit coll;
      d = $urandom_range(0, N - 1);
      r = $urandom_range(0, 9);
      coll = 1'b0;
      if (r < 6) begin
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        coll = ($urandom_range(0, 4) == 0);
      end else if (r < 8) begin
        a = $urandom;
        a[1:0] = 2'($urandom_range(1, 3));
      end else if (r == 8) begin
        a = $urandom;
        a[1:0] = 2'b00;
        if (a < 32'h400) a = a + 32'h400;
      end else begin
        a = 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, 255), $urandom);
      fetch(d, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), coll, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
